// File: rtl/array_op_sequencer.sv
// Clocked initiator for the combinational multiply/divide array: registers operands onto the
// array, waits a counted settle interval, then returns the result on a valid/ready handshake.
module array_op_sequencer #(
  parameter int unsigned NO_ROWS       = 10,
  parameter int unsigned NO_BITS_DIV   = 5,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           REQ_VALID,
  output logic                           REQ_READY,
  input  logic                           REQ_MUL_BAR,
  input  logic [NO_ROWS-1:0]             REQ_Y,
  input  logic [NO_BITS_DIV-1:0]         REQ_X,
  output logic [NO_ROWS-1:0]             ARR_Y,
  output logic [NO_BITS_DIV-1:0]         ARR_X,
  output logic                           ARR_MUL_BAR,
  input  logic [NO_ROWS+NO_BITS_DIV-2:0] ARR_REM_MUL_OUT,
  input  logic [NO_ROWS-1:0]             ARR_Q,
  output logic                           RSP_VALID,
  input  logic                           RSP_READY,
  output logic                           RSP_MUL_BAR,
  output logic [NO_ROWS+NO_BITS_DIV-2:0] RSP_REM_MUL_OUT,
  output logic [NO_ROWS-1:0]             RSP_Q,
  output logic                           RSP_DIV0,
  output logic                           BUSY
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic [7:0] CntLoad = 8'(SETTLE_CYCLES - 1);

  logic [1:0]                     r_state;
  logic [7:0]                     r_cnt;
  logic                           r_div0;
  logic [NO_ROWS-1:0]             r_arr_y;
  logic [NO_BITS_DIV-1:0]         r_arr_x;
  logic                           r_arr_mul_bar;
  logic                           r_rsp_mul_bar;
  logic [NO_ROWS+NO_BITS_DIV-2:0] r_rsp_rem_mul;
  logic [NO_ROWS-1:0]             r_rsp_q;
  logic                           r_rsp_div0;

  logic w_accept;

  assign w_accept = REQ_VALID && (r_state == StIdle);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= StIdle;
      r_cnt         <= 8'd0;
      r_div0        <= 1'b0;
      r_arr_y       <= '0;
      r_arr_x       <= '0;
      r_arr_mul_bar <= 1'b0;
      r_rsp_mul_bar <= 1'b0;
      r_rsp_rem_mul <= '0;
      r_rsp_q       <= '0;
      r_rsp_div0    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          // Array inputs only move on accept so the array outputs stay quiet while idle.
          if (w_accept) begin
            r_arr_y       <= REQ_Y;
            r_arr_x       <= REQ_X;
            r_arr_mul_bar <= REQ_MUL_BAR;
            r_div0        <= REQ_MUL_BAR && (REQ_X == '0);
            r_cnt         <= CntLoad;
            r_state       <= StSettle;
          end
        end
        StSettle: begin
          if (r_cnt == 8'd0) begin
            r_rsp_rem_mul <= ARR_REM_MUL_OUT;
            r_rsp_q       <= r_arr_mul_bar ? ARR_Q : '0;
            r_rsp_mul_bar <= r_arr_mul_bar;
            r_rsp_div0    <= r_div0;
            r_state       <= StResp;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        StResp: begin
          if (RSP_READY) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign REQ_READY       = (r_state == StIdle);
  assign BUSY            = (r_state != StIdle);
  assign RSP_VALID       = (r_state == StResp);
  assign ARR_Y           = r_arr_y;
  assign ARR_X           = r_arr_x;
  assign ARR_MUL_BAR     = r_arr_mul_bar;
  assign RSP_MUL_BAR     = r_rsp_mul_bar;
  assign RSP_REM_MUL_OUT = r_rsp_rem_mul;
  assign RSP_Q           = r_rsp_q;
  assign RSP_DIV0        = r_rsp_div0;

endmodule

// File: tb/tb_array_op_sequencer.sv
// Directed bench for array_op_sequencer with a behavioural array model and a result scoreboard.
module tb_array_op_sequencer;

  localparam int unsigned Settle = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_MUL_BAR;
  logic [9:0]  REQ_Y;
  logic [4:0]  REQ_X;
  logic [9:0]  ARR_Y;
  logic [4:0]  ARR_X;
  logic        ARR_MUL_BAR;
  logic [13:0] ARR_REM_MUL_OUT;
  logic [9:0]  ARR_Q;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic        RSP_MUL_BAR;
  logic [13:0] RSP_REM_MUL_OUT;
  logic [9:0]  RSP_Q;
  logic        RSP_DIV0;
  logic        BUSY;

  always #5 CLK = ~CLK;

  array_op_sequencer #(
    .NO_ROWS      (10),
    .NO_BITS_DIV  (5),
    .SETTLE_CYCLES(Settle)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .REQ_VALID      (REQ_VALID),
    .REQ_READY      (REQ_READY),
    .REQ_MUL_BAR    (REQ_MUL_BAR),
    .REQ_Y          (REQ_Y),
    .REQ_X          (REQ_X),
    .ARR_Y          (ARR_Y),
    .ARR_X          (ARR_X),
    .ARR_MUL_BAR    (ARR_MUL_BAR),
    .ARR_REM_MUL_OUT(ARR_REM_MUL_OUT),
    .ARR_Q          (ARR_Q),
    .RSP_VALID      (RSP_VALID),
    .RSP_READY      (RSP_READY),
    .RSP_MUL_BAR    (RSP_MUL_BAR),
    .RSP_REM_MUL_OUT(RSP_REM_MUL_OUT),
    .RSP_Q          (RSP_Q),
    .RSP_DIV0       (RSP_DIV0),
    .BUSY           (BUSY)
  );

  // Array stand-in; in MUL mode Q carries junk so the sequencer's zeroing is visible.
  always_comb begin
    ARR_REM_MUL_OUT = '0;
    ARR_Q           = 10'h2AA;
    if (!ARR_MUL_BAR) begin
      ARR_REM_MUL_OUT = 14'(ARR_Y) * 14'(ARR_X);
    end else if (ARR_X == 5'd0) begin
      ARR_Q           = '1;
      ARR_REM_MUL_OUT = 14'(ARR_Y);
    end else begin
      ARR_Q           = ARR_Y / 10'(ARR_X);
      ARR_REM_MUL_OUT = 14'(ARR_Y % 10'(ARR_X));
    end
  end

  typedef struct packed {
    logic        mb;
    logic [13:0] rem;
    logic [9:0]  q;
    logic        div0;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  int   accept_cycle = 0;

  function automatic exp_t model(input logic mb, input logic [9:0] y, input logic [4:0] x);
    exp_t e;
    e.mb   = mb;
    e.div0 = mb && (x == 5'd0);
    if (!mb) begin
      e.rem = 14'(y) * 14'(x);
      e.q   = '0;
    end else if (x == 5'd0) begin
      e.q   = '1;
      e.rem = 14'(y);
    end else begin
      e.q   = y / 10'(x);
      e.rem = 14'(y % 10'(x));
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cycle++;
  endtask

  task automatic send(input logic mb, input logic [9:0] y, input logic [4:0] x);
    bit ok = 1'b0;
    REQ_MUL_BAR = mb;
    REQ_Y       = y;
    REQ_X       = x;
    REQ_VALID   = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (REQ_READY) ok = 1'b1;
      tick();
    end
    REQ_VALID = 1'b0;
    check("accept_seen", 32'(ok), 32'd1);
    accept_cycle = cycle;
    sb.push_back(model(mb, y, x));
  endtask

  task automatic expect_rsp(input string tag);
    exp_t e;
    bit   busy_ok = 1'b1;
    for (int i = 0; i < 300 && !RSP_VALID; i++) begin
      if (!BUSY || REQ_READY) busy_ok = 1'b0;
      tick();
    end
    check({tag, "_valid"}, 32'(RSP_VALID), 32'd1);
    check({tag, "_busy_settle"}, 32'(busy_ok), 32'd1);
    check({tag, "_latency"}, 32'(cycle - accept_cycle), 32'(Settle));
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_mul_bar"}, 32'(RSP_MUL_BAR), 32'(e.mb));
      check({tag, "_rem_mul"}, 32'(RSP_REM_MUL_OUT), 32'(e.rem));
      check({tag, "_q"}, 32'(RSP_Q), 32'(e.q));
      check({tag, "_div0"}, 32'(RSP_DIV0), 32'(e.div0));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 32'(REQ_READY), 32'd1);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_rsp_valid"}, 32'(RSP_VALID), 32'd0);
    check({tag, "_arr"}, {17'(ARR_Y), 5'(ARR_X), 10'(ARR_MUL_BAR)}, 32'd0);
    check({tag, "_rsp"}, {RSP_REM_MUL_OUT, RSP_Q, RSP_MUL_BAR, RSP_DIV0, 6'd0}, 32'd0);
  endtask

  initial begin
    int  t1;
    bit  bp_ok;
    bit  no_pulse;
    RST         = 1'b1;
    REQ_VALID   = 1'b0;
    REQ_MUL_BAR = 1'b0;
    REQ_Y       = '0;
    REQ_X       = '0;
    RSP_READY   = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check_reset_state("reset");

    // MUL 31*31, then response drops after the handshake edge.
    send(1'b0, 10'd31, 5'd31);
    expect_rsp("mul31");
    check("mul31_literal", 32'(RSP_REM_MUL_OUT), 32'd961);
    check("mul31_q_zero", 32'(RSP_Q), 32'd0);
    tick();
    check("mul31_valid_drop", 32'(RSP_VALID), 32'd0);
    check("mul31_idle_ready", 32'(REQ_READY), 32'd1);

    send(1'b1, 10'd1023, 5'd15);
    expect_rsp("div1023");
    check("div1023_q_literal", 32'(RSP_Q), 32'd68);
    check("div1023_r_literal", 32'(RSP_REM_MUL_OUT), 32'd3);
    tick();

    send(1'b1, 10'd3, 5'd0);
    expect_rsp("div0");
    check("div0_flag_literal", 32'(RSP_DIV0), 32'd1);
    check("div0_q_literal", 32'(RSP_Q), 32'd1023);
    tick();

    // Backpressure: response held while a competing request pulses.
    RSP_READY = 1'b0;
    send(1'b1, 10'd365, 5'd15);
    expect_rsp("bp");
    REQ_MUL_BAR = 1'b0;
    REQ_Y       = 10'd7;
    REQ_X       = 5'd9;
    bp_ok       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      REQ_VALID = (i % 2 == 0);
      tick();
      if (!(RSP_VALID && RSP_Q == 10'd24 && RSP_REM_MUL_OUT == 14'd5 && !REQ_READY &&
            ARR_Y == 10'd365 && BUSY)) bp_ok = 1'b0;
    end
    REQ_VALID = 1'b0;
    check("bp_stable", 32'(bp_ok), 32'd1);
    RSP_READY = 1'b1;
    send(1'b0, 10'd7, 5'd9);
    expect_rsp("bp_next");
    tick();

    // Reset during SETTLE abandons the operation.
    send(1'b0, 10'd23, 5'd8);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    void'(sb.pop_back());
    check_reset_state("midrst");
    no_pulse = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (RSP_VALID) no_pulse = 1'b0;
    end
    check("midrst_no_rsp", 32'(no_pulse), 32'd1);

    // Back-to-back with RSP_READY held high.
    send(1'b0, 10'd21, 5'd15);
    expect_rsp("b2b_mul");
    check("b2b_mul_literal", 32'(RSP_REM_MUL_OUT), 32'd315);
    t1 = cycle;
    send(1'b1, 10'd21, 5'd15);
    expect_rsp("b2b_div");
    check("b2b_spacing", 32'(cycle - t1), 32'(Settle + 2));
    check("b2b_div_q_literal", 32'(RSP_Q), 32'd1);
    check("b2b_div_r_literal", 32'(RSP_REM_MUL_OUT), 32'd6);
    tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
